xy_settle_filter: RTL and testbench

//  Downstream consumer of the gate-delay x/y logic stage (circuit_with_delay).
//  - Synchronises the asynchronous x/y outputs into the clock domain.
//  - Rejects hazard glitches caused by unequal gate delays.
//  - Emits each settled new {x,y} value once over a valid/ready interface.
//  - Counts rejected glitches for characterisation runs.

---
 rtl/xy_settle_if.sv | 18 +
 rtl/xy_settle_filter.sv | 136 +++++++++++++
 tb/tb_xy_settle_filter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_settle_if.sv
// Valid/ready channel carrying one settled {x,y} value from the filter to its consumer.
interface xy_settle_if;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_xy;

  modport master (
    output out_valid,
    output out_xy,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_xy,
    output out_ready
  );
endinterface

// File: rtl/xy_settle_filter.sv
// Synchronises the asynchronous x/y logic-stage outputs, rejects hazard glitches and
// emits each newly settled {x,y} once over a one-entry valid/ready buffer.
module xy_settle_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_in,
  input  logic             y_in,
  input  logic             en,
  xy_settle_if.master      out_if,
  output logic             glitch_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             overflow
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  state_t           state;
  logic [1:0]       stable_val;
  logic [1:0]       cand;
  logic [RUN_W-1:0] run_cnt;

  logic s_is_cand;
  logic s_is_stable;
  logic run_done;
  logic settle_evt;
  logic glitch_evt;
  logic buf_free;
  logic handshake;

  // Stage p0/p1: two-flop synchroniser; sync_p1 is the sampled value the filter judges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= {x_in, y_in};
      sync_p1 <= sync_p0;
    end
  end

  assign s_is_cand   = (sync_p1 == cand);
  assign s_is_stable = (sync_p1 == stable_val);
  assign run_done    = (run_cnt == RUN_LAST);
  assign settle_evt  = en && (state == PENDING) && s_is_cand && run_done;
  assign glitch_evt  = en && (state == PENDING) && s_is_stable;
  assign handshake   = out_if.out_valid && out_if.out_ready;
  assign buf_free    = !out_if.out_valid || out_if.out_ready;

  // Settle FSM: a candidate must repeat STABLE_CYCLES samples in a row to be accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STABLE;
      stable_val <= 2'b00;
      cand       <= 2'b00;
      run_cnt    <= '0;
    end else if (!en) begin
      state      <= STABLE;
      stable_val <= sync_p1;
      run_cnt    <= '0;
    end else begin
      unique case (state)
        STABLE: begin
          if (!s_is_stable) begin
            state   <= PENDING;
            cand    <= sync_p1;
            run_cnt <= RUN_ONE;
          end
        end
        PENDING: begin
          if (s_is_cand) begin
            if (run_done) begin
              state      <= STABLE;
              stable_val <= cand;
              run_cnt    <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else if (s_is_stable) begin
            // Returned to the old value before settling: a hazard glitch
            state   <= STABLE;
            run_cnt <= '0;
          end else begin
            cand    <= sync_p1;
            run_cnt <= RUN_ONE;
          end
        end
        default: begin
          state   <= STABLE;
          run_cnt <= '0;
        end
      endcase
    end
  end

  // Output stage: one-entry buffer, glitch strobe and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_if.out_valid <= 1'b0;
      out_if.out_xy    <= 2'b00;
      glitch_pulse     <= 1'b0;
      glitch_cnt       <= '0;
      overflow         <= 1'b0;
    end else begin
      glitch_pulse <= glitch_evt;
      if (glitch_evt) begin
        glitch_cnt <= sat_inc(glitch_cnt);
      end
      if (settle_evt && buf_free) begin
        out_if.out_valid <= 1'b1;
        out_if.out_xy    <= cand;
      end else if (settle_evt) begin
        // Consumer is stalled on an older value; keep it and flag the loss
        overflow <= 1'b1;
      end else if (handshake) begin
        out_if.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xy_settle_filter.sv
// Self-checking bench for xy_settle_filter: directed scenarios plus randomized traffic
// compared against a run-length reference model of the settle rules.
module tb_xy_settle_filter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic x_in = 1'b0;
  logic y_in = 1'b0;
  logic en = 1'b1;
  logic out_ready = 1'b0;

  logic       gp8, gp2, ov8, ov2;
  logic [7:0] gc8;
  logic [1:0] gc2;

  xy_settle_if bus8 ();
  xy_settle_if bus2 ();
  assign bus8.out_ready = out_ready;
  assign bus2.out_ready = out_ready;

  xy_settle_filter #(.STABLE_CYCLES(N), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .en(en),
    .out_if(bus8.master), .glitch_pulse(gp8), .glitch_cnt(gc8), .overflow(ov8)
  );

  xy_settle_filter #(.STABLE_CYCLES(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .en(en),
    .out_if(bus2.master), .glitch_pulse(gp2), .glitch_cnt(gc2), .overflow(ov2)
  );

  int total = 0;
  int bad = 0;

  // Reference model: history of sampled inputs, run length of the current new value,
  // total glitches (saturation applied only when comparing).
  typedef struct packed {
    logic [1:0] h0;
    logic [1:0] h1;
    logic [1:0] stable;
    logic [1:0] runval;
    int         run;
    logic       valid;
    logic [1:0] xy;
    logic       ovf;
    logic       gp;
    int         gtot;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t step(mstate_t c, logic rstn, logic [1:0] xin, logic ena, logic rdy);
    mstate_t n;
    logic [1:0] s;
    logic evt;
    n = c;
    s = c.h1;
    evt = 1'b0;
    if (!rstn) begin
      n = '0;
      return n;
    end
    n.h0 = xin;
    n.h1 = c.h0;
    n.gp = 1'b0;
    if (!ena) begin
      n.stable = s;
      n.run = 0;
    end else if (c.run > 0 && s == c.stable) begin
      n.gp = 1'b1;
      n.gtot = c.gtot + 1;
      n.run = 0;
    end else if (s != c.stable) begin
      if (c.run > 0 && s == c.runval) begin
        n.run = c.run + 1;
      end else begin
        n.run = 1;
        n.runval = s;
      end
      if (n.run == N) begin
        evt = 1'b1;
        n.stable = s;
        n.run = 0;
      end
    end
    if (evt) begin
      if (!c.valid || rdy) begin
        n.valid = 1'b1;
        n.xy = s;
      end else begin
        n.ovf = 1'b1;
      end
    end else if (c.valid && rdy) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  function automatic int sat(int v, int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge clk) m <= step(m, rst_n, {x_in, y_in}, en, out_ready);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x_in = 1'b1; y_in = 1'b1; en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({bus8.out_valid, bus8.out_xy, gp8, gc8, ov8, gc2} !== 15'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=0", i,
                 {bus8.out_valid, bus8.out_xy, gp8, gc8, ov8, gc2});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total++;
      if (bus8.out_valid !== 1'(k >= 6)) begin
        bad++;
        $display("FAIL reset_latency edge=%0d got=%b want=%b", k, bus8.out_valid, 1'(k >= 6));
      end
      if (k == 6) begin
        total++;
        if (bus8.out_xy !== 2'b11) begin
          bad++;
          $display("FAIL reset_xy got=%b want=11", bus8.out_xy);
        end
      end
    end
    out_ready = 1'b1;
    cyc();
    total++;
    if (bus8.out_valid !== 1'b0 || m.valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_drain got=%b model=%b want=0", bus8.out_valid, m.valid);
    end
  endtask

  task automatic test_settle();
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (6) cyc();
    x_in = 1'b1; y_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      total++;
      if (bus8.out_valid !== 1'(k == 6)) begin
        bad++;
        $display("FAIL settle_valid edge=%0d got=%b want=%b", k, bus8.out_valid, 1'(k == 6));
      end
      total++;
      if ({bus8.out_valid, bus8.out_xy, gp8, ov8} !== {m.valid, m.xy, m.gp, m.ovf} || gc8 !== 8'd0) begin
        bad++;
        $display("FAIL settle_model edge=%0d got=%b cnt=%0d want=%b cnt=0", k,
                 {bus8.out_valid, bus8.out_xy, gp8, ov8}, gc8, {m.valid, m.xy, m.gp, m.ovf});
      end
    end
    total++;
    if (bus8.out_xy !== 2'b11) begin
      bad++;
      $display("FAIL settle_xy got=%b want=11", bus8.out_xy);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (4) cyc();
    x_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 1) x_in = 1'b0;
      if (gp8 === 1'b1) pulses++;
      total++;
      if (bus8.out_valid !== 1'b0 || gp8 !== m.gp) begin
        bad++;
        $display("FAIL glitch_cycle k=%0d valid=%b pulse=%b want valid=0 pulse=%b", k, bus8.out_valid, gp8, m.gp);
      end
    end
    total++;
    if (pulses != 1 || gc8 !== 8'd1) begin
      bad++;
      $display("FAIL glitch_count pulses=%0d cnt=%0d want pulses=1 cnt=1", pulses, gc8);
    end
  endtask

  task automatic test_overflow();
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b0;
    do_reset();
    x_in = 1'b0; y_in = 1'b1;
    repeat (8) cyc();
    total++;
    if ({bus8.out_valid, bus8.out_xy, ov8} !== 4'b1_01_0) begin
      bad++;
      $display("FAIL ovf_first got=%b want=1010", {bus8.out_valid, bus8.out_xy, ov8});
    end
    x_in = 1'b1; y_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      total++;
      if ({bus8.out_valid, bus8.out_xy, ov8} !== {m.valid, m.xy, m.ovf}) begin
        bad++;
        $display("FAIL ovf_model k=%0d got=%b want=%b", k, {bus8.out_valid, bus8.out_xy, ov8}, {m.valid, m.xy, m.ovf});
      end
    end
    total++;
    if ({bus8.out_valid, bus8.out_xy, ov8} !== 4'b1_01_1) begin
      bad++;
      $display("FAIL ovf_dropped got=%b want=1011", {bus8.out_valid, bus8.out_xy, ov8});
    end
    out_ready = 1'b1;
    cyc();
    total++;
    if (bus8.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_handshake valid=%b want=0", bus8.out_valid);
    end
    cyc();
    total++;
    if ({bus8.out_valid, ov8, bus8.out_xy} !== 4'b0_1_01) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=0101", {bus8.out_valid, ov8, bus8.out_xy});
    end
  endtask

  task automatic test_saturate();
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (3) cyc();
    for (int g = 0; g < 5; g++) begin
      x_in = 1'b1;
      cyc();
      x_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
        cyc();
        total++;
        if (gc2 !== 2'(sat(m.gtot, 2)) || gc8 !== 8'(sat(m.gtot, 8)) || gp2 !== m.gp) begin
          bad++;
          $display("FAIL sat_model g=%0d k=%0d cnt2=%0d cnt8=%0d want %0d/%0d", g, k, gc2, gc8,
                   sat(m.gtot, 2), sat(m.gtot, 8));
        end
      end
    end
    total++;
    if (gc2 !== 2'd3 || gc8 !== 8'd5) begin
      bad++;
      $display("FAIL sat_final cnt2=%0d cnt8=%0d want 3/5", gc2, gc8);
    end
  endtask

  task automatic test_reset_pending();
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b1;
    do_reset();
    repeat (3) cyc();
    x_in = 1'b1; y_in = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    x_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      total++;
      if ({bus8.out_valid, gp8, gc8, ov8} !== 11'b0) begin
        bad++;
        $display("FAIL rstpend k=%0d got=%b want=0", k, {bus8.out_valid, gp8, gc8, ov8});
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    x_in = 1'b0; y_in = 1'b0; en = 1'b1; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        {x_in, y_in} = 2'($urandom_range(0, 3));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 9);
      end
      hold--;
      if ($urandom_range(0, 29) == 0) en = ~en;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
      total++;
      if ({bus8.out_valid, bus8.out_xy, gp8, ov8} !== {m.valid, m.xy, m.gp, m.ovf} ||
          gc8 !== 8'(sat(m.gtot, 8)) || gc2 !== 2'(sat(m.gtot, 2)) || ov2 !== m.ovf) begin
        bad++;
        $display("FAIL random i=%0d got=%b cnt=%0d/%0d want=%b cnt=%0d/%0d", i,
                 {bus8.out_valid, bus8.out_xy, gp8, ov8}, gc8, gc2,
                 {m.valid, m.xy, m.gp, m.ovf}, sat(m.gtot, 8), sat(m.gtot, 2));
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_glitch();
    test_overflow();
    test_saturate();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
